l1_cache_nway: RTL
==================

Name: l1_cache_nway

Overview:
- Parametrised N-way set-associative L1 cache controller, single request channel; generalises the fixed 2-way, 64-set, 8-byte-line L1.
- Adds request/response handshake, round-robin replacement, write-through with no-write-allocate, and a full-cache flush.
- Sits between a core load/store or fetch port and the next memory level, which returns one full line per fill.

Parameters:
- ADDR_W, 16, byte address width.
- INDEX_W, 6, set index bits; SETS = 2**INDEX_W.
- OFFSET_W, 3, byte-in-line bits; LINE_W = 8*2**OFFSET_W.
- WAYS, 2, associativity, one of 1/2/4/8.
- TAG_W (derived), ADDR_W-INDEX_W-OFFSET_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=byte write, 0=byte read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  8  write byte
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  lookup hit for this request
- resp_rdata  out  8  read byte; 0 for writes
- flush  in  1  invalidate whole cache
- flush_busy  out  1  flush in progress
- mem_req  out  1  next-level request, held until mem_ack
- mem_we  out  1  1=write-through byte, 0=line fill
- mem_addr  out  ADDR_W  line-aligned for fills, full address for writes
- mem_wdata  out  8  write-through byte
- mem_ack  in  1  next level done; mem_rdata valid for fills
- mem_rdata  in  LINE_W  fill line

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset and storage:
  - rst clears all SETS*WAYS valid bits, every round-robin pointer, and all registered outputs; the state goes to IDLE.
  - Tag and data arrays are not reset.
  - Reset applied mid-fill or mid-write drops mem_req immediately, without waiting for a clock edge.
- Address split: tag = addr[ADDR_W-1 -: TAG_W]; index = addr[OFFSET_W +: INDEX_W]; offset = addr[OFFSET_W-1:0].
- Byte select: byte k of a line is bits [8k+7:8k].
- States: IDLE, LOOKUP, FILL, WRITE_THRU, FLUSH.
- IDLE:
  - req_ready=1 only in IDLE with flush low.
  - flush takes priority over req_valid: go to FLUSH.
  - Otherwise req_valid latches the request and the state goes to LOOKUP.
- LOOKUP (one cycle): compare all ways in parallel; a way hits when it is valid and its tag matches.
  - Read hit: resp_valid pulses in the next cycle with resp_hit=1 and the byte; go to IDLE. Latency is 2 cycles from the accepting edge.
  - Read miss: record miss and go to FILL.
  - Write hit: write the byte into the hit way; then go to WRITE_THRU.
  - Write miss: go to WRITE_THRU; no allocation.
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr = request address with offset cleared, held until mem_ack.
  - On mem_ack, write mem_rdata to the victim way, set valid and tag, advance the set pointer, and return to LOOKUP.
  - Re-lookup then hits, but the response reports resp_hit=0 because the miss was recorded.
- Victim selection: lowest-numbered invalid way; if all ways are valid, the per-set round-robin pointer. The pointer advances (mod WAYS) on every fill.
- WRITE_THRU: drive mem_req=1, mem_we=1 with the full address and byte. On mem_ack, resp_valid pulses with resp_hit equal to the lookup result; go to IDLE.
- mem_ack handling:
  - mem_ack is legal in the first cycle mem_req is asserted.
  - mem_ack is ignored outside FILL and WRITE_THRU.
- FLUSH:
  - Counter runs 0..SETS-1, clearing one set's valid bits and pointer per cycle.
  - flush_busy=1 and req_ready=0 throughout, for exactly SETS cycles; then go to IDLE.
  - flush asserted outside IDLE is ignored; the requester holds it until flush_busy is seen.

Optional Feature:
- Macro: L1_CACHE_STATS_EN.
- Defined: adds outputs stat_hits[15:0] and stat_misses[15:0].
  - Each increments by 1 in the response cycle, per resp_hit.
  - Both saturate at 16'hFFFF.
  - Both are cleared by rst and by flush entry.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package l1_cache_pkg holds:
  - the state_t enum (IDLE, LOOKUP, FILL, WRITE_THRU, FLUSH);
  - localparam functions for TAG_W and LINE_W;
  - a byte_sel function.
- Sub-module l1_cache_victim_sel: combinational; valid vector plus pointer in, way index out.

Test Plan (defaults; 0x1234 -> index 6, tag 9, offset 4):
- Cold read 0x1234:
  - Expect mem_req with mem_addr=0x1230 and mem_we=0.
  - Ack with mem_rdata=0x0807060504030201 -> resp_hit=0, resp_rdata=0x05.
  - Then read 0x1235 -> resp_hit=1, rdata=0x06, no mem_req, resp_valid 2 cycles after accept.
- Conflict on set 6:
  - Read 0x1234, then 0x1434, then 0x1634 -> fills land in way0, way1, then way0.
  - Re-read 0x1234 misses; 0x1434 hits.
- Write hit:
  - After a fill of 0x1230, write 0x1236 with 0xAA -> mem_we=1, mem_addr=0x1236, mem_wdata=0xAA; resp_hit=1.
  - Read 0x1236 -> 0xAA, no mem_req.
- Write miss:
  - Write 0x2000 with 0x55 -> write-through only, resp_hit=0.
  - Read 0x2000 misses (no-allocate).
- Flush:
  - One-cycle flush pulse after fills -> flush_busy and req_ready=0 for exactly 64 cycles.
  - Read 0x1235 then misses; with L1_CACHE_STATS_EN, both counters read 0 before that read.
- Async reset:
  - Assert rst mid-FILL between clock edges -> mem_req=0 immediately.
  - After release, read 0x1234 misses.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the N-way L1 cache controller.
package l1_cache_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        FILL       = 3'd2,
        WRITE_THRU = 3'd3,
        FLUSH      = 3'd4
    } state_t;

    // byte_sel works on the widest supported line; callers zero-extend.
    localparam int MAX_OFFSET_W = 6;
    localparam int MAX_LINE_W   = 8 * (2 ** MAX_OFFSET_W);

    function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int calc_line_w(input int offset_w);
        return 8 * (2 ** offset_w);
    endfunction

    function automatic logic [7:0] byte_sel(input logic [MAX_LINE_W-1:0] line,
                                            input logic [MAX_OFFSET_W-1:0] offset);
        return line[{offset, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/l1_cache_victim_sel.sv
// Victim way choice: lowest-numbered invalid way, else the round-robin pointer.
module l1_cache_victim_sel
    import l1_cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int PTR_W = 1
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] way
);

    // Scan downwards so the last invalid way seen is the lowest-numbered one.
    always_comb begin
        way = ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            way = valid[w] ? way : PTR_W'(w);
        end
    end

endmodule

// File: rtl/l1_cache_nway.sv
// N-way set-associative write-through, no-write-allocate L1 cache controller.
// Optional hit/miss counters are enabled by defining L1_CACHE_STATS_EN.
module l1_cache_nway
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 3,
    parameter int WAYS     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [7:0]                      req_wdata,
    output logic                            resp_valid,
    output logic                            resp_hit,
    output logic [7:0]                      resp_rdata,
    input  logic                            flush,
    output logic                            flush_busy,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [7:0]                      mem_wdata,
    input  logic                            mem_ack,
`ifdef L1_CACHE_STATS_EN
    output logic [15:0]                     stat_hits,
    output logic [15:0]                     stat_misses,
`endif
    input  logic [calc_line_w(OFFSET_W)-1:0] mem_rdata
);

    localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINE_W = calc_line_w(OFFSET_W);
    localparam int SETS   = 2 ** INDEX_W;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t               state_r;
    logic                 req_we_r;
    logic [ADDR_W-1:0]    req_addr_r;
    logic [7:0]           req_wdata_r;
    logic                 miss_r;
    logic                 hit_r;
    logic [INDEX_W-1:0]   flush_cnt_r;

    logic [WAYS-1:0]      valid_r [SETS];
    logic [PTR_W-1:0]     ptr_r   [SETS];
    logic [TAG_W-1:0]     tag_r   [SETS][WAYS];
    logic [LINE_W-1:0]    data_r  [SETS][WAYS];

    logic [TAG_W-1:0]     tag_s;
    logic [INDEX_W-1:0]   idx_s;
    logic [OFFSET_W-1:0]  off_s;
    logic [WAYS-1:0]      hit_vec_s;
    logic                 hit_s;
    logic [PTR_W-1:0]     hit_way_s;
    logic [PTR_W-1:0]     victim_s;
    logic [7:0]           hit_byte_s;
    logic                 fill_en_s;
    logic                 wr_hit_en_s;

    assign tag_s       = req_addr_r[ADDR_W-1 -: TAG_W];
    assign idx_s       = req_addr_r[OFFSET_W +: INDEX_W];
    assign off_s       = req_addr_r[OFFSET_W-1:0];
    assign req_ready   = (state_r == IDLE) && !flush;
    assign fill_en_s   = (state_r == FILL) && mem_ack;
    assign wr_hit_en_s = (state_r == LOOKUP) && req_we_r && hit_s;
    assign hit_byte_s  = byte_sel(MAX_LINE_W'(data_r[idx_s][hit_way_s]), MAX_OFFSET_W'(off_s));

    // Parallel tag compare; hit_vec_s is at most one-hot, so OR-encoding yields the way.
    always_comb begin
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s);
            hit_way_s    = hit_way_s | (hit_vec_s[w] ? PTR_W'(w) : PTR_W'(0));
        end
        hit_s = |hit_vec_s;
    end

    l1_cache_victim_sel #(
        .WAYS  (WAYS),
        .PTR_W (PTR_W)
    ) u_victim_sel (
        .valid (valid_r[idx_s]),
        .ptr   (ptr_r[idx_s]),
        .way   (victim_s)
    );

    // Tag and data storage carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (fill_en_s) begin
            tag_r[idx_s][victim_s]  <= tag_s;
            data_r[idx_s][victim_s] <= mem_rdata;
        end else if (wr_hit_en_s) begin
            data_r[idx_s][hit_way_s][{off_s, 3'b000} +: 8] <= req_wdata_r;
        end
    end

    // Control FSM with registered handshake, memory and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            req_we_r    <= 1'b0;
            req_addr_r  <= '0;
            req_wdata_r <= 8'h00;
            miss_r      <= 1'b0;
            hit_r       <= 1'b0;
            flush_cnt_r <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_rdata  <= 8'h00;
            flush_busy  <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                ptr_r[s]   <= '0;
            end
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        flush_cnt_r <= '0;
                        flush_busy  <= 1'b1;
                        state_r     <= FLUSH;
                    end else if (req_valid) begin
                        req_we_r    <= req_we;
                        req_addr_r  <= req_addr;
                        req_wdata_r <= req_wdata;
                        miss_r      <= 1'b0;
                        state_r     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_we_r) begin
                        hit_r     <= hit_s;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= req_addr_r;
                        mem_wdata <= req_wdata_r;
                        state_r   <= WRITE_THRU;
                    end else if (hit_s) begin
                        resp_valid <= 1'b1;
                        resp_hit   <= !miss_r;
                        resp_rdata <= hit_byte_s;
                        state_r    <= IDLE;
                    end else begin
                        miss_r   <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_addr_r[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        state_r  <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req                  <= 1'b0;
                        valid_r[idx_s][victim_s] <= 1'b1;
                        ptr_r[idx_s]             <= (ptr_r[idx_s] == PTR_W'(WAYS - 1)) ?
                                                    PTR_W'(0) : ptr_r[idx_s] + PTR_W'(1);
                        state_r                  <= LOOKUP;
                    end
                end
                WRITE_THRU: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_hit   <= hit_r;
                        resp_rdata <= 8'h00;
                        state_r    <= IDLE;
                    end
                end
                FLUSH: begin
                    valid_r[flush_cnt_r] <= '0;
                    ptr_r[flush_cnt_r]   <= '0;
                    if (flush_cnt_r == INDEX_W'(SETS - 1)) begin
                        flush_busy <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + INDEX_W'(1);
                    end
                end
                default: begin
                    mem_req    <= 1'b0;
                    flush_busy <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

`ifdef L1_CACHE_STATS_EN
    // Saturating hit/miss counters; flush entry takes precedence over a same-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= 16'h0000;
            stat_misses <= 16'h0000;
        end else if ((state_r == IDLE) && flush) begin
            stat_hits   <= 16'h0000;
            stat_misses <= 16'h0000;
        end else if (resp_valid) begin
            if (resp_hit) begin
                stat_hits <= (stat_hits == 16'hFFFF) ? stat_hits : stat_hits + 16'd1;
            end else begin
                stat_misses <= (stat_misses == 16'hFFFF) ? stat_misses : stat_misses + 16'd1;
            end
        end
    end
`endif

endmodule
